// File: rtl/gray_pkg.sv
// Shared Gray-code constants and conversions for the Gray counter and its benches.
// Conversions operate on the widest legal code; callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] value);
        return value ^ (value >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result intact.
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] value);
        logic [GRAY_WIDTH_MAX-1:0] result;
        result[GRAY_WIDTH_MAX-1] = value[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            result[i] = result[i+1] ^ value[i];
        end
        return result;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide (2..16).
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    assign g = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(b)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter publishing a registered Gray code and a one-cycle wrap pulse.
// Define GRAY_COUNTER_STEP_CHECK_EN to add a sticky err output flagging non-unit Gray steps.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
`ifdef GRAY_COUNTER_STEP_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (load) begin
            w_bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                w_bin_next  = r_bin + ONE;
                w_wrap_next = (r_bin == '1);
            end else begin
                w_bin_next  = r_bin - ONE;
                w_wrap_next = (r_bin == '0);
            end
        end
    end

    // Gray is encoded from the next binary value so bin and gray update on the same edge.
    bin_to_gray #(
        .WIDTH(WIDTH)
    ) u_bin_to_gray (
        .b(w_bin_next),
        .g(w_gray_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;

`ifdef GRAY_COUNTER_STEP_CHECK_EN
    logic r_err;
    logic w_step;

    assign w_step = en & ~load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_step && ($countones(r_gray ^ w_gray_next) != 1)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4): directed scenarios plus randomized run
// against an arithmetic reference model; err is checked when GRAY_COUNTER_STEP_CHECK_EN is set.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
`ifdef GRAY_COUNTER_STEP_CHECK_EN
    logic         err;
`endif

    int n_pass  = 0;
    int n_total = 0;

    int   m_bin  = 0;
    logic m_wrap = 1'b0;

    always #5 clk = ~clk;

    gray_counter #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_bin(load_bin),
        .bin     (bin),
        .gray    (gray),
        .wrap    (wrap)
`ifdef GRAY_COUNTER_STEP_CHECK_EN
        ,
        .err     (err)
`endif
    );

    function automatic logic [W-1:0] ref_gray(input int b);
        return W'(b ^ (b / 2));
    endfunction

    function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic l, input logic e, input logic u,
                         input logic [W-1:0] lb);
        rst = r; load = l; en = e; up = u; load_bin = lb;
        if (r) begin
            m_bin = 0; m_wrap = 1'b0;
        end else if (l) begin
            m_bin = int'(lb); m_wrap = 1'b0;
        end else if (e && u) begin
            m_wrap = (m_bin == MOD - 1);
            m_bin  = (m_bin + 1) % MOD;
        end else if (e) begin
            m_wrap = (m_bin == 0);
            m_bin  = (m_bin + MOD - 1) % MOD;
        end else begin
            m_wrap = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
            n_total++;
            if (bin !== 4'b0000) $display("FAIL reset_bin cyc%0d got %b want 0000", i, bin);
            else n_pass++;
            n_total++;
            if (gray !== 4'b0000) $display("FAIL reset_gray cyc%0d got %b want 0000", i, gray);
            else n_pass++;
            n_total++;
            if (wrap !== 1'b0) $display("FAIL reset_wrap cyc%0d got %b want 0", i, wrap);
            else n_pass++;
        end
    endtask

    task automatic test_up_sweep();
        logic [W-1:0] exp_g [17] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                     4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                     4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
            n_total++;
            if (gray !== exp_g[i]) $display("FAIL up_gray step%0d got %b want %b", i, gray, exp_g[i]);
            else n_pass++;
            n_total++;
            if (wrap !== (exp_g[i] == 4'b0000))
                $display("FAIL up_wrap step%0d got %b want %b", i, wrap, exp_g[i] == 4'b0000);
            else n_pass++;
            n_total++;
            if (ref_decode(gray) !== bin)
                $display("FAIL up_decode step%0d got %b want %b", i, ref_decode(gray), bin);
            else n_pass++;
            n_total++;
            if (bin !== W'(m_bin)) $display("FAIL up_bin step%0d got %b want %b", i, bin, W'(m_bin));
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_total++;
        if (bin !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1)
            $display("FAIL down_wrap got bin=%b gray=%b wrap=%b want 1111/1000/1", bin, gray, wrap);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        n_total++;
        if (bin !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0)
            $display("FAIL down_next got bin=%b gray=%b wrap=%b want 1110/1001/0", bin, gray, wrap);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
        n_total++;
        if (bin !== 4'b1010 || gray !== 4'b1111 || wrap !== 1'b0)
            $display("FAIL load_prio got bin=%b gray=%b wrap=%b want 1010/1111/0", bin, gray, wrap);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 1), 4'($urandom));
            n_total++;
            if (bin !== 4'b1010 || gray !== 4'b1111 || wrap !== 1'b0)
                $display("FAIL hold cyc%0d got bin=%b gray=%b wrap=%b want 1010/1111/0",
                         i, bin, gray, wrap);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0101);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        n_total++;
        if (bin !== 4'b0110) $display("FAIL midrst_pre got %b want 0110", bin);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, '0);
        n_total++;
        if (bin !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0)
            $display("FAIL midrst_rst got bin=%b gray=%b wrap=%b want 0000/0000/0", bin, gray, wrap);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        n_total++;
        if (bin !== 4'b0001 || gray !== 4'b0001)
            $display("FAIL midrst_resume got bin=%b gray=%b want 0001/0001", bin, gray);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        n_total++;
        if (bin !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b0)
            $display("FAIL b2b_load got bin=%b gray=%b wrap=%b want 1111/1000/0", bin, gray, wrap);
        else n_pass++;
        // Full down sweep and alternating directions exercise the step checker.
        for (int i = 0; i < MOD; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, logic'(i % 2), '0);
        n_total++;
        if (bin !== W'(m_bin) || wrap !== m_wrap)
            $display("FAIL b2b_sweep got bin=%b wrap=%b want %b/%b", bin, wrap, W'(m_bin), m_wrap);
        else n_pass++;
`ifdef GRAY_COUNTER_STEP_CHECK_EN
        n_total++;
        if (err !== 1'b0) $display("FAIL b2b_err got %b want 0", err);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic         r, l, e, u;
        logic [W-1:0] lb;
        logic [W-1:0] prev_gray;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            lb = W'($urandom);
            prev_gray = gray;
            cycle(r, l, e, u, lb);
            n_total++;
            if (bin !== W'(m_bin) || gray !== ref_gray(m_bin) || wrap !== m_wrap)
                $display("FAIL rand_state cyc%0d got bin=%b gray=%b wrap=%b want %b/%b/%b",
                         i, bin, gray, wrap, W'(m_bin), ref_gray(m_bin), m_wrap);
            else n_pass++;
            if (!r && !l && e) begin
                n_total++;
                if ($countones(gray ^ prev_gray) != 1)
                    $display("FAIL rand_unit_step cyc%0d got %b->%b want one bit change",
                             i, prev_gray, gray);
                else n_pass++;
            end
`ifdef GRAY_COUNTER_STEP_CHECK_EN
            n_total++;
            if (err !== 1'b0) $display("FAIL rand_err cyc%0d got %b want 0", i, err);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load_priority();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
